// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned multiply (shift-add) / divide (restoring) sequencer that
// borrows the shared ALU one operation per cycle and leaves the result in hi/lo.
module alu_muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            mode,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            busy,
    output logic            done,
    output logic            div_by_zero,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic [3:0]      alu_op,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] alu_z
);
    localparam int CW = $clog2(XLEN);
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state_reg, state_next;
    logic [XLEN-1:0] hi_reg, hi_next;
    logic [XLEN-1:0] lo_reg, lo_next;
    logic [XLEN-1:0] m_reg, m_next;
    logic [CW-1:0]   count_reg, count_next;
    logic            mode_reg, mode_next;
    logic            dbz_reg, dbz_next;

    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] add_b;
    logic            carry;
    logic            borrow;

    assign sh    = {hi_reg[XLEN-2:0], lo_reg[XLEN-1]};
    assign add_b = lo_reg[0] ? m_reg : '0;

    // Operand steering: the ALU is parked on AND 0,0 whenever we are not stepping.
    always_comb begin
        alu_op = OP_AND;
        alu_a  = '0;
        alu_b  = '0;
        if (state_reg == S_RUN) begin
            if (mode_reg) begin
                alu_op = OP_SUB;
                alu_a  = sh;
                alu_b  = m_reg;
            end else begin
                alu_op = OP_ADD;
                alu_a  = hi_reg;
                alu_b  = add_b;
            end
        end
    end

    // The ALU has no carry-out, so recover carry/borrow from the operand and result MSBs.
    assign carry  = (alu_a[XLEN-1] & alu_b[XLEN-1]) |
                    ((alu_a[XLEN-1] | alu_b[XLEN-1]) & ~alu_z[XLEN-1]);
    assign borrow = (~alu_a[XLEN-1] & alu_b[XLEN-1]) |
                    (~(alu_a[XLEN-1] ^ alu_b[XLEN-1]) & alu_z[XLEN-1]);

    always_comb begin
        state_next = state_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        m_next     = m_reg;
        count_next = count_reg;
        mode_next  = mode_reg;
        dbz_next   = dbz_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    mode_next  = mode;
                    m_next     = src_b;
                    dbz_next   = 1'b0;
                    count_next = '0;
                    if (mode && (src_b == '0)) begin
                        hi_next    = src_a;
                        lo_next    = '1;
                        dbz_next   = 1'b1;
                        state_next = S_DONE;
                    end else begin
                        hi_next    = '0;
                        lo_next    = src_a;
                        state_next = S_RUN;
                    end
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (mode_reg) begin
                    // A set msb means the 33-bit partial remainder always covers m.
                    if (hi_reg[XLEN-1] | ~borrow) begin
                        hi_next = alu_z;
                        lo_next = {lo_reg[XLEN-2:0], 1'b1};
                    end else begin
                        hi_next = sh;
                        lo_next = {lo_reg[XLEN-2:0], 1'b0};
                    end
                end else begin
                    hi_next = {carry, alu_z[XLEN-1:1]};
                    lo_next = {alu_z[0], lo_reg[XLEN-1:1]};
                end
                count_next = count_reg + 1'b1;
                if (count_reg == CW'(XLEN - 1)) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            hi_reg    <= '0;
            lo_reg    <= '0;
            m_reg     <= '0;
            count_reg <= '0;
            mode_reg  <= 1'b0;
            dbz_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
            m_reg     <= m_next;
            count_reg <= count_next;
            mode_reg  <= mode_next;
            dbz_reg   <= dbz_next;
        end
    end

    assign hi          = hi_reg;
    assign lo          = lo_reg;
    assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq: vector table of mul/div results plus
// hand-written protocol sequences (ignored start, async abort, back-to-back).
module tb_alu_muldiv_seq;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic        mode;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [3:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_z;

    int checks;
    int failures;

    alu_muldiv_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .mode        (mode),
        .src_a       (src_a),
        .src_b       (src_b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo),
        .alu_op      (alu_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_z       (alu_z)
    );

    // Behavioural stand-in for the shared execute-stage ALU.
    always_comb begin
        case (alu_op)
            4'b0000: alu_z = alu_a & alu_b;
            4'b0010: alu_z = alu_a + alu_b;
            4'b0110: alu_z = alu_a - alu_b;
            default: alu_z = 32'h0;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        md;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_dbz;
        int          exp_lat;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic md, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        mode  = md;
        src_a = a;
        src_b = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Returns cycles from accept edge to the done cycle, RUN cycles seen, and bad opcodes.
    task automatic wait_done(input logic md, output int lat, output int busy_cnt, output int op_bad);
        int n;
        n = 0;
        busy_cnt = 0;
        op_bad = 0;
        while (!done && n < 40) begin
            if (busy) busy_cnt++;
            if (busy && alu_op !== (md ? 4'b0110 : 4'b0010)) op_bad++;
            @(posedge clk);
            #1;
            n++;
        end
        lat = n + 1;
    endtask

    initial begin
        int lat, bc, ob, c, first, seen;
        checks   = 0;
        failures = 0;
        start    = 1'b0;
        mode     = 1'b0;
        src_a    = 32'h0;
        src_b    = 32'h0;
        rst_n    = 1'b0;

        vecs[0] = '{1'b0, 32'd7,         32'd6,         32'h0,         32'd42,        1'b0, 33};
        vecs[1] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33};
        vecs[2] = '{1'b0, 32'h8000_0000, 32'd2,         32'h1,         32'h0,         1'b0, 33};
        vecs[3] = '{1'b0, 32'h1234_5678, 32'h10,        32'h1,         32'h2345_6780, 1'b0, 33};
        vecs[4] = '{1'b1, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 33};
        vecs[5] = '{1'b1, 32'hFFFF_FFFF, 32'd1,         32'h0,         32'hFFFF_FFFF, 1'b0, 33};
        vecs[6] = '{1'b1, 32'h8000_0001, 32'h8000_0000, 32'h1,         32'h1,         1'b0, 33};
        vecs[7] = '{1'b1, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1, 1};
        vecs[8] = '{1'b0, 32'd3,         32'd4,         32'h0,         32'd12,        1'b0, 33};
        vecs[9] = '{1'b1, 32'd0,         32'd3,         32'h0,         32'h0,         1'b0, 33};

        #12;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_dbz", 32'(div_by_zero), 32'h0);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_op", 32'(alu_op), 32'h0);
        chk("idle_a", alu_a, 32'h0);
        chk("idle_b", alu_b, 32'h0);

        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].md, vecs[i].a, vecs[i].b);
            wait_done(vecs[i].md, lat, bc, ob);
            $display("vec %0d mode=%0d a=%h b=%h -> hi=%h lo=%h dbz=%0d lat=%0d",
                     i, vecs[i].md, vecs[i].a, vecs[i].b, hi, lo, div_by_zero, lat);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
            chk($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
            chk($sformatf("v%0d_dbz", i), 32'(div_by_zero), 32'(vecs[i].exp_dbz));
            chk($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'(vecs[i].exp_lat - 1));
            chk($sformatf("v%0d_run_opcode", i), 32'(ob), 32'h0);
            chk($sformatf("v%0d_done_busy", i), 32'(busy), 32'h0);
            chk($sformatf("v%0d_done_alu", i), {alu_op, alu_a[27:0] | alu_b[27:0]}, 32'h0);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_done_pulse", i), 32'(done), 32'h0);
            chk($sformatf("v%0d_hold_hi", i), hi, vecs[i].exp_hi);
            chk($sformatf("v%0d_hold_lo", i), lo, vecs[i].exp_lo);
        end

        // start pulsed in RUN cycle 5 must be ignored
        issue(1'b0, 32'd7, 32'd6);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        start = 1'b1;
        src_a = 32'd100;
        src_b = 32'd100;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(1'b0, lat, bc, ob);
        $display("ignored-start seq: hi=%h lo=%h lat=%0d", hi, lo, lat);
        chk("ign_done_seen", 32'(done), 32'h1);
        chk("ign_lo", lo, 32'd42);
        chk("ign_hi", hi, 32'h0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("ign_no_requeue", 32'(busy), 32'h0);

        // async reset in RUN cycle 10 aborts without done
        issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        chk("abort_busy_before", 32'(busy), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        $display("async abort: busy=%0d hi=%h lo=%h", busy, hi, lo);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_hi", hi, 32'h0);
        chk("abort_lo", lo, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        chk("abort_no_done", 32'(seen), 32'h0);
        issue(1'b0, 32'd9, 32'd9);
        wait_done(1'b0, lat, bc, ob);
        $display("post-abort 9x9: hi=%h lo=%h lat=%0d", hi, lo, lat);
        chk("abort_9x9_lo", lo, 32'd81);
        chk("abort_9x9_lat", 32'(lat), 32'd33);

        // back-to-back with start held high
        @(negedge clk);
        start = 1'b1;
        mode  = 1'b0;
        src_a = 32'd2;
        src_b = 32'd3;
        c = 0;
        while (!done && c < 100) begin
            @(posedge clk);
            #1;
            c++;
        end
        first = c;
        @(posedge clk);
        #1;
        c++;
        while (!done && c < 200) begin
            @(posedge clk);
            #1;
            c++;
        end
        start = 1'b0;
        $display("back-to-back: done spacing=%0d lo=%h", c - first, lo);
        chk("b2b_spacing", 32'(c - first), 32'd34);
        chk("b2b_lo", lo, 32'd6);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("b2b_stop", 32'(busy), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Multi-cycle controller that sequences the shared 32-bit ALU to perform unsigned multiply (shift-add) and unsigned divide (restoring).
- Issues one ALU operation per cycle and holds the 64-bit result in HI/LO, MIPS convention.
- Sits beside the execute stage and drives the ALU op/a/b inputs. The ALU's z result is fed back combinationally.

Parameters:
- XLEN, 32, datapath width. Must equal the ALU width; only 32 is supported.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- mode  in  1  0 = multiply, 1 = divide
- src_a  in  32  multiplicand / dividend
- src_b  in  32  multiplier / divisor
- busy  out  1  high from the cycle after accept until done
- done  out  1  one-cycle completion pulse
- div_by_zero  out  1  set with done when mode=1 and src_b=0; held until next accept
- hi  out  32  product[63:32] / remainder
- lo  out  32  product[31:0] / quotient
- alu_op  out  4  ALU opcode: AND=0000, ADD=0010, SUB=0110
- alu_a  out  32  ALU operand a
- alu_b  out  32  ALU operand b
- alu_z  in  32  ALU result, combinational from alu_op/alu_a/alu_b

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE; busy=0, done=0, div_by_zero=0.
  - hi=0, lo=0, iteration count=0, internal operand register=0.
  - Reset mid-operation aborts the operation; no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - alu_op=AND, alu_a=0, alu_b=0.
  - On start=1, capture mode and src_b (internal register m), and set div_by_zero=0.
  - Multiply accept: hi=0, lo=src_a, count=0 -> RUN.
  - Divide accept with src_b=0: hi=src_a, lo=32'hFFFF_FFFF, div_by_zero=1 -> DONE.
  - Divide accept with src_b≠0: hi=0, lo=src_a, count=0 -> RUN.
- RUN, multiply (one step per cycle):
  - alu_op=ADD, alu_a=hi, alu_b = lo[0] ? m : 0.
  - carry = (alu_a[31]&alu_b[31]) | ((alu_a[31]|alu_b[31]) & ~alu_z[31]).
  - {hi,lo} <= {carry, alu_z, lo[31:1]}.
- RUN, divide (one step per cycle):
  - sh = {hi[30:0], lo[31]}, msb = hi[31].
  - alu_op=SUB, alu_a=sh, alu_b=m.
  - borrow = (~alu_a[31]&alu_b[31]) | (~(alu_a[31]^alu_b[31]) & alu_z[31]).
  - If msb | ~borrow: hi<=alu_z, lo<={lo[30:0],1}. Else: hi<=sh, lo<={lo[30:0],0}.
- RUN exit: count increments each RUN cycle; after the 32nd step (count==31) -> DONE.
- DONE:
  - done=1 for exactly one cycle, busy=0, ALU driven as in IDLE -> IDLE.
  - start is ignored in DONE.
- Latency:
  - Accept edge = edge 0. RUN occupies edges 1..32.
  - done is high in the cycle following edge 32 (33 cycles after accept).
  - Divide-by-zero: done is high in the cycle following edge 0.
- busy is 1 in every RUN cycle and 0 in IDLE and DONE.
- start while busy or in DONE is ignored, with no queuing.
- hi/lo/div_by_zero hold their values until the next accept or reset.
- All arithmetic is unsigned. The ALU supplies no carry-out; carry and borrow are reconstructed from operand and result MSBs as above.

Test Plan:
- Multiply 7×6: start mode=0, a=7, b=6 -> done exactly 33 cycles after accept; hi=0, lo=42; busy high for 32 cycles.
- Multiply carry: a=b=32'hFFFF_FFFF -> hi=32'hFFFF_FFFE, lo=32'h0000_0001; a=32'h8000_0000, b=2 -> hi=1, lo=0.
- Divide: 100/7 -> lo=14, hi=2. 32'hFFFF_FFFF/1 -> lo=32'hFFFF_FFFF, hi=0. 32'h8000_0001/32'h8000_0000 -> lo=1, hi=1 (exercises the msb path). Check alu_op=0110 on all 32 RUN cycles.
- Divide by zero: 5/0 -> done 1 cycle after accept; div_by_zero=1, hi=5, lo=32'hFFFF_FFFF, busy never high. Next accepted multiply clears div_by_zero.
- Protocol:
  - Pulse start again at RUN cycle 5 with different operands -> ignored; first result is unchanged.
  - Deassert rst_n asynchronously at RUN cycle 10 -> busy=0, hi=lo=0 immediately, no done pulse.
  - After release, 9×9 gives lo=81.
- Idle ALU drive: in IDLE and DONE, alu_op=0000, alu_a=alu_b=0. Back-to-back operations with start held high give accepts exactly one cycle after each done.
